// File: rtl/stream_fifo_pkg.sv
// Shared constants and elaboration helpers for the streaming FIFO.
package stream_fifo_pkg;

    // Storage style hints passed through to the RAM.
    localparam string RamStyleAuto        = "auto";
    localparam string RamStyleBlock       = "block";
    localparam string RamStyleDistributed = "distributed";

    // Width needed to represent 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Address width for a RAM of 'depth' words (at least one bit).
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Legal combination of capacity and flag thresholds.
    function automatic bit params_ok(input int unsigned depth, input int unsigned afull,
                                     input int unsigned aempty);
        return (depth >= 2) && (afull >= 1) && (afull <= depth) && (aempty <= depth - 1);
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port RAM: one write port and one synchronous read port with registered data.
module stream_fifo_ram
    import stream_fifo_pkg::*;
#(
    parameter int unsigned  WIDTH     = 8,
    parameter int unsigned  DEPTH     = 16,
    parameter string        RAM_STYLE = RamStyleAuto,
    localparam int unsigned AW        = addr_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    if (RAM_STYLE != RamStyleAuto && RAM_STYLE != RamStyleBlock &&
        RAM_STYLE != RamStyleDistributed) begin : g_bad_style
        $error("stream_fifo_ram: unsupported RAM_STYLE");
    end

    (* ram_style = RAM_STYLE *) logic [WIDTH-1:0] mem_q [DEPTH];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port; data is valid the cycle after re_i.
    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/streaming_fifo_ctrl.sv
// AXI-Stream FIFO: RAM storage behind a 2-entry first-word-fall-through prefetch stage,
// with exact occupancy, almost-full/almost-empty flags, flush and a high-watermark register.
module streaming_fifo_ctrl
    import stream_fifo_pkg::*;
#(
    parameter int unsigned  WIDTH         = 8,
    parameter int unsigned  DEPTH         = 16384,
    parameter int unsigned  AFULL_THRESH  = DEPTH - 2,
    parameter int unsigned  AEMPTY_THRESH = 2,
    parameter string        RAM_STYLE     = RamStyleAuto,
    localparam int unsigned CW            = cnt_width(DEPTH)
) (
    input  logic             ap_clk,
    input  logic             ap_rst,
    input  logic             flush,
    input  logic             max_clr,
    output logic [CW-1:0]    count,
    output logic [CW-1:0]    max_count,
    output logic             almost_full,
    output logic             almost_empty,
    input  logic [WIDTH-1:0] in0_V_V_TDATA,
    input  logic             in0_V_V_TVALID,
    output logic             in0_V_V_TREADY,
    output logic [WIDTH-1:0] out_V_V_TDATA,
    output logic             out_V_V_TVALID,
    input  logic             out_V_V_TREADY
);

    localparam int unsigned AW = addr_width(DEPTH);

    if (!params_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_params
        $error("streaming_fifo_ctrl: illegal DEPTH/AFULL_THRESH/AEMPTY_THRESH");
    end

    // RAM pointers and the number of words in RAM not yet read out.
    logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]    ram_cnt_q, ram_cnt_d;
    // A RAM read was issued last cycle; its data is on ram_rdata now.
    logic             rd_vld_q;
    // Prefetch stage: pf0 is the head presented on the output.
    logic [1:0]       pf_cnt_q, pf_cnt_d;
    logic [WIDTH-1:0] pf0_q, pf0_d, pf1_q, pf1_d;
    // Occupancy, watermark and flags.
    logic [CW-1:0]    count_q, count_d, max_q, max_d;
    logic             afull_q, afull_d, aempty_q, aempty_d, full_q, full_d;
    logic             ovld_q, ovld_d, rdy_q;

    logic             push, pop, rd_en;
    logic [2:0]       pf_after;
    logic [WIDTH-1:0] ram_rdata;

    assign in0_V_V_TREADY = rdy_q & ~full_q & ~flush;
    assign out_V_V_TVALID = ovld_q;
    assign out_V_V_TDATA  = pf0_q;
    assign count          = count_q;
    assign max_count      = max_q;
    assign almost_full    = afull_q;
    assign almost_empty   = aempty_q;

    assign push = in0_V_V_TVALID & in0_V_V_TREADY;
    assign pop  = ovld_q & out_V_V_TREADY;

    // Only read from RAM when the returning word is guaranteed a prefetch slot.
    assign pf_after = {1'b0, pf_cnt_q} + {2'b00, rd_vld_q} - {2'b00, pop};
    assign rd_en    = (ram_cnt_q != '0) && !flush && (pf_after < 3'd2);

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        // Explicit wrap so non-power-of-two depths work.
        if (p == AW'(DEPTH - 1)) begin
            return '0;
        end
        return p + AW'(1);
    endfunction

    stream_fifo_ram #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RAM_STYLE (RAM_STYLE)
    ) u_ram (
        .clk_i   (ap_clk),
        .we_i    (push),
        .waddr_i (wptr_q),
        .wdata_i (in0_V_V_TDATA),
        .re_i    (rd_en),
        .raddr_i (rptr_q),
        .rdata_o (ram_rdata)
    );

    // Next-state for pointers, RAM occupancy, prefetch stage and total count.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        ram_cnt_d = ram_cnt_q;
        pf_cnt_d  = pf_cnt_q;
        pf0_d     = pf0_q;
        pf1_d     = pf1_q;
        count_d   = count_q;

        if (push) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (rd_en) begin
            rptr_d = ptr_inc(rptr_q);
        end
        if (push && !rd_en) begin
            ram_cnt_d = ram_cnt_q + CW'(1);
        end else if (!push && rd_en) begin
            ram_cnt_d = ram_cnt_q - CW'(1);
        end

        // Retire the head first, then append the word returning from RAM.
        if (pop) begin
            pf0_d    = pf1_q;
            pf_cnt_d = pf_cnt_q - 2'd1;
        end
        if (rd_vld_q) begin
            if (pf_cnt_d == 2'd0) begin
                pf0_d = ram_rdata;
            end else begin
                pf1_d = ram_rdata;
            end
            pf_cnt_d = pf_cnt_d + 2'd1;
        end

        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end

        // Flush discards everything; a pop on the same edge has already completed.
        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            ram_cnt_d = '0;
            pf_cnt_d  = '0;
            count_d   = '0;
        end
    end

    // Flags and watermark are derived from next-state count so they track count exactly.
    always_comb begin
        afull_d  = (count_d >= CW'(AFULL_THRESH));
        aempty_d = (count_d <= CW'(AEMPTY_THRESH));
        full_d   = (count_d == CW'(DEPTH));
        ovld_d   = (pf_cnt_d != 2'd0);
        if (max_clr) begin
            max_d = count_d;
        end else begin
            max_d = (count_d > max_q) ? count_d : max_q;
        end
    end

    // Pointer, occupancy and prefetch state.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            ram_cnt_q <= '0;
            rd_vld_q  <= 1'b0;
            pf_cnt_q  <= '0;
            pf0_q     <= '0;
            pf1_q     <= '0;
            count_q   <= '0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            ram_cnt_q <= ram_cnt_d;
            rd_vld_q  <= rd_en;
            pf_cnt_q  <= pf_cnt_d;
            pf0_q     <= pf0_d;
            pf1_q     <= pf1_d;
            count_q   <= count_d;
        end
    end

    // Registered status outputs; rdy_q holds TREADY low until the first edge after reset.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            max_q    <= '0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            full_q   <= 1'b0;
            ovld_q   <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            max_q    <= max_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            full_q   <= full_d;
            ovld_q   <= ovld_d;
            rdy_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_streaming_fifo_ctrl.sv
// Scoreboard bench for streaming_fifo_ctrl: a DEPTH=16 instance for directed and random traffic
// and a DEPTH=5 instance for random traffic, both checked against queue-based reference models.
module tb_streaming_fifo_ctrl;
    import stream_fifo_pkg::*;

    logic ap_clk = 1'b0;
    logic ap_rst;
    always #5 ap_clk = ~ap_clk;

    // Instance A: DEPTH=16, AFULL=14, AEMPTY=2.
    logic       a_flush, a_mclr, a_ivld, a_irdy, a_ovld, a_ordy, a_af, a_ae;
    logic [7:0] a_idata, a_odata;
    logic [4:0] a_cnt, a_max;
    // Instance B: DEPTH=5, AFULL=3, AEMPTY=2.
    logic       b_flush, b_mclr, b_ivld, b_irdy, b_ovld, b_ordy, b_af, b_ae;
    logic [7:0] b_idata, b_odata;
    logic [2:0] b_cnt, b_max;

    streaming_fifo_ctrl #(
        .WIDTH(8), .DEPTH(16), .AFULL_THRESH(14), .AEMPTY_THRESH(2), .RAM_STYLE(RamStyleBlock)
    ) u_dut_a (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .flush(a_flush), .max_clr(a_mclr),
        .count(a_cnt), .max_count(a_max), .almost_full(a_af), .almost_empty(a_ae),
        .in0_V_V_TDATA(a_idata), .in0_V_V_TVALID(a_ivld), .in0_V_V_TREADY(a_irdy),
        .out_V_V_TDATA(a_odata), .out_V_V_TVALID(a_ovld), .out_V_V_TREADY(a_ordy)
    );

    streaming_fifo_ctrl #(
        .WIDTH(8), .DEPTH(5), .AFULL_THRESH(3), .AEMPTY_THRESH(2),
        .RAM_STYLE(RamStyleDistributed)
    ) u_dut_b (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .flush(b_flush), .max_clr(b_mclr),
        .count(b_cnt), .max_count(b_max), .almost_full(b_af), .almost_empty(b_ae),
        .in0_V_V_TDATA(b_idata), .in0_V_V_TVALID(b_ivld), .in0_V_V_TREADY(b_irdy),
        .out_V_V_TDATA(b_odata), .out_V_V_TVALID(b_ovld), .out_V_V_TREADY(b_ordy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the FIFO contents as a plain queue per instance.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         max_m[2];
    bit         rdy_ok[2];

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    // Compare outputs to the model, then advance the model by the handshakes of the coming edge.
    task automatic mon(input int k, input int depth, input int afull, input int aempty,
                       input logic rst, input logic flush, input logic mclr,
                       input logic ivld, input logic irdy, input logic [7:0] idata,
                       input logic ovld, input logic ordy, input logic [7:0] odata,
                       input int cnt, input int maxc, input logic af, input logic ae);
        int         n;
        logic [7:0] e;
        string      p;
        p = (k == 0) ? "d16" : "d5";
        if (rst) begin
            chk({p, " rst count"}, cnt, 0);
            chk({p, " rst max"}, maxc, 0);
            chk({p, " rst tvalid"}, ovld, 0);
            chk({p, " rst tdata"}, odata, 0);
            chk({p, " rst afull"}, af, 0);
            chk({p, " rst aempty"}, ae, 1);
            chk({p, " rst tready"}, irdy, 0);
            if (k == 0) q0.delete(); else q1.delete();
            max_m[k]  = 0;
            rdy_ok[k] = 1'b0;
        end else begin
            n = qsize(k);
            chk({p, " count"}, cnt, n);
            chk({p, " max_count"}, maxc, max_m[k]);
            chk({p, " almost_full"}, af, int'(n >= afull));
            chk({p, " almost_empty"}, ae, int'(n <= aempty));
            chk({p, " tready"}, irdy, int'(rdy_ok[k] && n < depth && !flush));
            if (n == 0) chk({p, " tvalid when empty"}, ovld, 0);
            if (ovld && ordy && n > 0) begin
                if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                chk({p, " tdata"}, odata, e);
            end
            if (ivld && irdy) begin
                if (k == 0) q0.push_back(idata); else q1.push_back(idata);
            end
            if (flush) begin
                if (k == 0) q0.delete(); else q1.delete();
            end
            n         = qsize(k);
            max_m[k]  = mclr ? n : ((n > max_m[k]) ? n : max_m[k]);
            rdy_ok[k] = 1'b1;
        end
    endtask

    // Monitor samples mid-cycle, away from the active edge.
    always @(negedge ap_clk) begin
        mon(0, 16, 14, 2, ap_rst, a_flush, a_mclr, a_ivld, a_irdy, a_idata, a_ovld, a_ordy,
            a_odata, int'(a_cnt), int'(a_max), a_af, a_ae);
        mon(1, 5, 3, 2, ap_rst, b_flush, b_mclr, b_ivld, b_irdy, b_idata, b_ovld, b_ordy,
            b_odata, int'(b_cnt), int'(b_max), b_af, b_ae);
    end

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    bit acc_a, acc_b;
    int pa, pb;

    initial begin
        ap_rst  = 1'b1;
        a_flush = 0; a_mclr = 0; a_ivld = 0; a_idata = 0; a_ordy = 0;
        b_flush = 0; b_mclr = 0; b_ivld = 0; b_idata = 0; b_ordy = 0;
        repeat (3) step();
        ap_rst = 1'b0;
        step();

        // Latency and ordering: word k pushed at edge k is presented after edge k+2.
        a_ordy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            a_ivld  = (c < 16);
            a_idata = 8'(c + 1);
            @(negedge ap_clk);
            chk("latency tvalid", a_ovld, int'(c >= 3 && c <= 18));
            if (c >= 3 && c <= 18) chk("latency tdata", a_odata, c - 2);
            step();
        end
        a_ivld = 1'b0;
        a_ordy = 1'b0;

        // Fill to capacity with the output stalled.
        for (int i = 0; i < 16; i++) begin
            a_ivld  = 1'b1;
            a_idata = 8'($urandom);
            step();
        end
        a_ivld = 1'b0;
        repeat (3) step();
        @(negedge ap_clk);
        chk("full count", a_cnt, 16);
        chk("full tready", a_irdy, 0);
        chk("full almost_full", a_af, 1);
        chk("full tvalid", a_ovld, 1);
        chk("full max_count", a_max, 16);

        // Push and pop together at full: only the pop is taken.
        step();
        a_ivld  = 1'b1;
        a_idata = 8'hAA;
        a_ordy  = 1'b1;
        @(negedge ap_clk);
        chk("full pushpop tready", a_irdy, 0);
        step();
        a_ordy = 1'b0;
        @(negedge ap_clk);
        chk("after full pop count", a_cnt, 15);
        chk("after full pop tready", a_irdy, 1);
        step();
        a_ivld = 1'b0;

        // Drain completely.
        a_ordy = 1'b1;
        for (int i = 0; i < 40 && a_cnt != 0; i++) step();
        a_ordy = 1'b0;
        @(negedge ap_clk);
        chk("drained count", a_cnt, 0);
        chk("drained tvalid", a_ovld, 0);
        chk("drained almost_empty", a_ae, 1);
        chk("drained max_count", a_max, 16);

        // Flush with ten words held and the output ready.
        step();
        a_mclr = 1'b1;
        step();
        a_mclr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_ivld  = 1'b1;
            a_idata = 8'($urandom);
            step();
        end
        a_ivld = 1'b0;
        repeat (3) step();
        a_flush = 1'b1;
        a_ordy  = 1'b1;
        @(negedge ap_clk);
        chk("flush tready", a_irdy, 0);
        step();
        a_flush = 1'b0;
        a_ordy  = 1'b0;
        @(negedge ap_clk);
        chk("flush count", a_cnt, 0);
        chk("flush tvalid", a_ovld, 0);
        chk("flush almost_empty", a_ae, 1);
        chk("flush almost_full", a_af, 0);
        chk("flush max_count", a_max, 10);
        step();
        a_ordy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_ivld  = 1'b1;
            a_idata = 8'(8'h50 + i);
            step();
        end
        a_ivld = 1'b0;
        repeat (6) step();
        chk("post-flush model empty", q0.size(), 0);

        // Random traffic on both instances with a mid-stream reset.
        pa = 0;
        pb = 0;
        for (int cyc = 0; cyc < 60000 && (pa < 10000 || pb < 10000); cyc++) begin
            @(negedge ap_clk);
            acc_a = a_ivld && a_irdy;
            acc_b = b_ivld && b_irdy;
            if (acc_a) pa++;
            if (acc_b) pb++;
            step();
            if (cyc == 3000) ap_rst = 1'b1;
            if (cyc == 3003) ap_rst = 1'b0;
            if (!a_ivld || acc_a) begin
                a_ivld  = ($urandom_range(0, 3) != 0);
                a_idata = 8'($urandom);
            end
            if (!b_ivld || acc_b) begin
                b_ivld  = ($urandom_range(0, 3) != 0);
                b_idata = 8'($urandom);
            end
            a_ordy  = ($urandom_range(0, 3) != 0);
            b_ordy  = ($urandom_range(0, 2) != 0);
            a_flush = ($urandom_range(0, 999) == 0);
            b_flush = ($urandom_range(0, 1499) == 0);
            a_mclr  = ($urandom_range(0, 499) == 0);
            b_mclr  = ($urandom_range(0, 499) == 0);
        end
        a_ivld = 0; b_ivld = 0; a_flush = 0; b_flush = 0; a_mclr = 0; b_mclr = 0;
        a_ordy = 1; b_ordy = 1;
        repeat (40) step();
        chk("random d16 progress", int'(pa >= 10000), 1);
        chk("random d5 progress", int'(pb >= 10000), 1);
        chk("random d16 drained", q0.size(), 0);
        chk("random d5 drained", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
